mem_stage_sram_ctrl: RTL and testbench
======================================

Name: mem_stage_sram_ctrl

Overview:
- Memory-stage controller directly downstream of the execute ALU.
- Takes the ALU result as the byte address for LDR/STR and performs one 32-bit word access on an external SRAM with a 16-bit data bus, as two half-word transfers.
- Holds `ready` low while an access is in flight; the pipeline hazard/freeze logic stalls on `!ready`.

Parameters:
- ADDR_BASE, 1024: byte offset subtracted from the ALU address before mapping to SRAM.
- WAIT_CYCLES, 2: cycles each half-word phase lasts; legal range 1..15.
- SRAM_AW, 18: SRAM half-word address width.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- rd_en  input  1  LDR in memory stage; held until ready.
- wr_en  input  1  STR in memory stage; held until ready.
- address  input  32  ALU result (byte address).
- write_data  input  32  store data (Rm value).
- read_data  output  32  loaded word, registered.
- ready  output  1  1 = no access pending or access completing this cycle.
- sram_addr  output  SRAM_AW  half-word address.
- sram_dq_out  output  16  write data to SRAM.
- sram_dq_oe  output  1  1 = drive sram_dq_out onto the bus.
- sram_dq_in  input  16  read data from SRAM.
- sram_we_n  output  1  active-low write strobe.

Behaviour:
- Clocking and reset:
  - Single clock clk; rst is synchronous, active-high.
  - On reset: state=IDLE, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, wait counter=0, latched address/data=0.
  - ready=1 in the cycle after reset.
- Address mapping:
  - eff = address - ADDR_BASE, 32-bit modulo; address < ADDR_BASE wraps silently.
  - Word index w = eff[SRAM_AW:2]; eff[1:0] is ignored.
  - Low half-word at sram_addr={w,0}; high half-word at {w,1}.
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE:
  - ready = ~(rd_en | wr_en).
  - On rd_en|wr_en: latch w, write_data and op (write if wr_en, else read), clear counter, go to LOW.
  - Both enables high: treated as a write; read_data unchanged.
- LOW:
  - sram_addr={w,0}.
  - Write op: sram_dq_out=data[15:0], sram_dq_oe=1, sram_we_n=0.
  - Read op: sram_we_n=1, sram_dq_oe=0.
  - Counter increments each cycle. When counter==WAIT_CYCLES-1: read op captures read_data[15:0]<=sram_dq_in; clear counter; go to HIGH.
- HIGH:
  - Same as LOW with {w,1} and data[31:16].
  - Read op captures read_data[31:16] on the last cycle; go to DONE.
- DONE:
  - ready=1, sram_we_n=1, sram_dq_oe=0.
  - Unconditionally go to IDLE. The enables seen in DONE belong to the completing instruction and are ignored.
- Latency:
  - Request first seen in IDLE at cycle 0 → ready=0 in cycles 0..2*WAIT_CYCLES, ready=1 in cycle 2*WAIT_CYCLES+1.
  - WAIT_CYCLES=2 gives 6 cycles per access.
- Back-to-back: the next request is recognised in the IDLE cycle after DONE; there is no idle bubble besides that cycle.
- read_data holds its last loaded value across writes and idle cycles. The low half may show the new value while the high half is still old; read_data is only valid when ready=1 after a read.
- Enables dropping mid-access: illegal. The access still completes; no abort.
- sram_we_n never glitches between phases. Outside LOW/HIGH writes, sram_we_n=1 and sram_dq_oe=0.
- Reset mid-access: next edge forces IDLE with reset values. No further strobes; the partial SRAM write is not undone.
- ready is combinational from state and the enables; all SRAM outputs are decoded from state and latched registers only, never from live inputs.

Test Plan:
- Idle after reset, rd_en=wr_en=0 for 5 cycles → ready=1, sram_we_n=1, sram_dq_oe=0, read_data=0 throughout.
- STR address=1024+8, write_data=32'hDEADBEEF, WAIT_CYCLES=2:
  - sram_addr=4 with dq=16'hBEEF, we_n=0 for 2 cycles.
  - Then sram_addr=5 with dq=16'hDEAD for 2 cycles.
  - ready=1 exactly in cycle 5.
- LDR address=1032 against an SRAM model holding that word → read_data=32'hDEADBEEF in the DONE cycle (cycle 5); value held through 10 later idle cycles.
- Back-to-back LDR 1024 then LDR 1028 with enables held continuously → first ready at cycle 5, second ready at cycle 11; sram_addr sequence 0,0,1,1,2,2,3,3.
- rst asserted during the HIGH phase of a write → next cycle state IDLE, sram_we_n=1, read_data=0, ready=1. A following LDR completes normally in 6 cycles.
- rd_en=wr_en=1 with address=1020 (wraps to eff=32'hFFFFFFFC) → handled as a write to sram_addr={w,0}/{w,1} with w=eff[18:2]; read_data unchanged.

Source files
------------

// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl
//
// Memory-stage controller behind the execute ALU. Each LDR/STR performs one
// 32-bit word access on an external SRAM with a 16-bit data bus, as two
// half-word phases (low half first). Each phase lasts WAIT_CYCLES cycles.
// The pipeline stalls while ready is low.
//
// Ports:
//   clk          pipeline clock, rising edge
//   rst          synchronous, active-high reset
//   rd_en        LDR in memory stage, held until ready
//   wr_en        STR in memory stage, held until ready (wins over rd_en)
//   address      ALU result, byte address
//   write_data   store data
//   read_data    loaded word, registered
//   ready        1 = no access pending, or access completing this cycle
//   sram_addr    SRAM half-word address
//   sram_dq_out  write data to SRAM
//   sram_dq_oe   1 = drive sram_dq_out onto the bus
//   sram_dq_in   read data from SRAM
//   sram_we_n    active-low write strobe

module mem_stage_sram_ctrl #(
    parameter int unsigned ADDR_BASE   = 1024,
    parameter int unsigned WAIT_CYCLES = 2,   // 1..15
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    localparam int unsigned WordW   = SRAM_AW - 1;
    localparam logic [3:0]  LastCnt = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [WordW-1:0]   word_q, word_d;
    logic [31:0]        data_q, data_d;
    logic               is_wr_q, is_wr_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [31:0]        eff;
    logic               req;
    logic               unused_eff;

    // Addresses below ADDR_BASE wrap modulo 2^32 by design.
    assign eff        = address - 32'(ADDR_BASE);
    assign unused_eff = ^{eff[31:SRAM_AW+1], eff[1:0]};
    assign req        = rd_en | wr_en;

    assign read_data  = rdata_q;

    // SRAM address and data depend only on state and latched registers.
    assign sram_addr   = {word_q, (state_q == StHigh)};
    assign sram_dq_out = (state_q == StHigh) ? data_q[31:16] : data_q[15:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        data_d     = data_q;
        is_wr_d    = is_wr_q;
        rdata_d    = rdata_q;
        ready      = 1'b0;
        sram_we_n  = 1'b1;
        sram_dq_oe = 1'b0;

        unique case (state_q)
            StIdle: begin
                ready = ~req;
                if (req) begin
                    word_d  = eff[SRAM_AW:2];
                    data_d  = write_data;
                    is_wr_d = wr_en;
                    cnt_d   = 4'd0;
                    state_d = StLow;
                end
            end
            StLow, StHigh: begin
                sram_we_n  = ~is_wr_q;
                sram_dq_oe = is_wr_q;
                if (cnt_q == LastCnt) begin
                    if (!is_wr_q) begin
                        if (state_q == StLow) begin
                            rdata_d[15:0] = sram_dq_in;
                        end else begin
                            rdata_d[31:16] = sram_dq_in;
                        end
                    end
                    cnt_d   = 4'd0;
                    state_d = (state_q == StLow) ? StHigh : StDone;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: begin
                // Enables here still belong to the completing instruction.
                ready   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            word_q  <= '0;
            data_q  <= 32'd0;
            is_wr_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            data_q  <= data_d;
            is_wr_q <= is_wr_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a small behavioural SRAM.

module tb_mem_stage_sram_ctrl;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    int n_checks;
    int n_errors;

    logic [15:0] mem [0:255];

    mem_stage_sram_ctrl #(
        .ADDR_BASE  (1024),
        .WAIT_CYCLES(2),
        .SRAM_AW    (18)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in),
        .sram_we_n  (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous-read SRAM, write on rising edge while we_n is low.
    assign sram_dq_in = mem[sram_addr[7:0]];
    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr[7:0]] <= sram_dq_out;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs/outputs are then sampled 2 time units after the edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Full access with no checks other than completion; returns to IDLE.
    task automatic run_access(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d);
        rd_en = r; wr_en = w; address = a; write_data = d;
        repeat (5) cyc();
        check_eq("run_access_ready", {31'd0, ready}, 32'd1);
        rd_en = 1'b0; wr_en = 1'b0;
        cyc();
    endtask

    logic [17:0] exp_addr [1:5];
    logic [15:0] exp_dq   [1:5];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = 32'd0; write_data = 32'd0;
        cyc(); cyc();
        rst = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 5; i++) begin
            cyc();
            check_eq("idle_ready", {31'd0, ready}, 32'd1);
            check_eq("idle_we_n", {31'd0, sram_we_n}, 32'd1);
            check_eq("idle_oe", {31'd0, sram_dq_oe}, 32'd0);
            check_eq("idle_rdata", read_data, 32'd0);
        end

        // STR 1032 <- DEADBEEF.
        exp_addr[1] = 18'd4; exp_addr[2] = 18'd4; exp_addr[3] = 18'd5; exp_addr[4] = 18'd5;
        exp_dq[1] = 16'hBEEF; exp_dq[2] = 16'hBEEF; exp_dq[3] = 16'hDEAD; exp_dq[4] = 16'hDEAD;
        wr_en = 1'b1; address = 32'd1032; write_data = 32'hDEADBEEF;
        #1;
        check_eq("str_c0_ready", {31'd0, ready}, 32'd0);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            check_eq("str_ready", {31'd0, ready}, 32'd0);
            check_eq("str_addr", {14'd0, sram_addr}, {14'd0, exp_addr[c]});
            check_eq("str_dq", {16'd0, sram_dq_out}, {16'd0, exp_dq[c]});
            check_eq("str_we_n", {31'd0, sram_we_n}, 32'd0);
            check_eq("str_oe", {31'd0, sram_dq_oe}, 32'd1);
        end
        cyc();
        check_eq("str_c5_ready", {31'd0, ready}, 32'd1);
        check_eq("str_c5_we_n", {31'd0, sram_we_n}, 32'd1);
        check_eq("str_c5_oe", {31'd0, sram_dq_oe}, 32'd0);
        wr_en = 1'b0;
        cyc();
        check_eq("str_after_ready", {31'd0, ready}, 32'd1);

        // LDR 1032.
        rd_en = 1'b1; address = 32'd1032;
        #1;
        check_eq("ldr_c0_ready", {31'd0, ready}, 32'd0);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            check_eq("ldr_ready", {31'd0, ready}, 32'd0);
            check_eq("ldr_we_n", {31'd0, sram_we_n}, 32'd1);
            check_eq("ldr_oe", {31'd0, sram_dq_oe}, 32'd0);
        end
        cyc();
        check_eq("ldr_c5_ready", {31'd0, ready}, 32'd1);
        check_eq("ldr_c5_rdata", read_data, 32'hDEADBEEF);
        rd_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check_eq("ldr_hold_rdata", read_data, 32'hDEADBEEF);
            check_eq("ldr_hold_ready", {31'd0, ready}, 32'd1);
        end

        // Preload words at 1024 and 1028.
        run_access(1'b0, 1'b1, 32'd1024, 32'h11112222);
        run_access(1'b0, 1'b1, 32'd1028, 32'h33334444);

        // Back-to-back LDR 1024 then 1028, enables held.
        exp_addr[1] = 18'd0; exp_addr[2] = 18'd0; exp_addr[3] = 18'd1; exp_addr[4] = 18'd1;
        rd_en = 1'b1; address = 32'd1024;
        #1;
        check_eq("b2b_c0_ready", {31'd0, ready}, 32'd0);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            check_eq("b2b_a_ready", {31'd0, ready}, 32'd0);
            check_eq("b2b_a_addr", {14'd0, sram_addr}, {14'd0, exp_addr[c]});
        end
        cyc();
        check_eq("b2b_c5_ready", {31'd0, ready}, 32'd1);
        check_eq("b2b_c5_rdata", read_data, 32'h11112222);
        address = 32'd1028;
        cyc();
        check_eq("b2b_c6_ready", {31'd0, ready}, 32'd0);
        exp_addr[1] = 18'd2; exp_addr[2] = 18'd2; exp_addr[3] = 18'd3; exp_addr[4] = 18'd3;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            check_eq("b2b_b_ready", {31'd0, ready}, 32'd0);
            check_eq("b2b_b_addr", {14'd0, sram_addr}, {14'd0, exp_addr[c]});
            if (c >= 3) check_eq("b2b_b_partial", read_data, 32'h11114444);
        end
        cyc();
        check_eq("b2b_c11_ready", {31'd0, ready}, 32'd1);
        check_eq("b2b_c11_rdata", read_data, 32'h33334444);
        rd_en = 1'b0;
        cyc();

        // Reset during HIGH phase of a write.
        wr_en = 1'b1; address = 32'd1040; write_data = 32'hAAAA5555;
        repeat (3) cyc();
        check_eq("rst_pre_addr", {14'd0, sram_addr}, 32'd9);
        check_eq("rst_pre_we_n", {31'd0, sram_we_n}, 32'd0);
        rst = 1'b1; wr_en = 1'b0;
        cyc();
        rst = 1'b0;
        #1;
        check_eq("rst_ready", {31'd0, ready}, 32'd1);
        check_eq("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        check_eq("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
        check_eq("rst_rdata", read_data, 32'd0);
        check_eq("rst_addr", {14'd0, sram_addr}, 32'd0);
        rd_en = 1'b1; address = 32'd1024;
        #1;
        check_eq("rst_ldr_c0", {31'd0, ready}, 32'd0);
        repeat (4) cyc();
        check_eq("rst_ldr_c4", {31'd0, ready}, 32'd0);
        cyc();
        check_eq("rst_ldr_c5", {31'd0, ready}, 32'd1);
        check_eq("rst_ldr_rdata", read_data, 32'h11112222);
        rd_en = 1'b0;
        cyc();

        // Both enables with wrapping address: treated as a write.
        rd_en = 1'b1; wr_en = 1'b1; address = 32'd1020; write_data = 32'h12345678;
        cyc();
        check_eq("both_lo_addr", {14'd0, sram_addr}, 32'h3FFFE);
        check_eq("both_lo_dq", {16'd0, sram_dq_out}, 32'h5678);
        check_eq("both_lo_we_n", {31'd0, sram_we_n}, 32'd0);
        repeat (2) cyc();
        check_eq("both_hi_addr", {14'd0, sram_addr}, 32'h3FFFF);
        check_eq("both_hi_dq", {16'd0, sram_dq_out}, 32'h1234);
        check_eq("both_hi_oe", {31'd0, sram_dq_oe}, 32'd1);
        repeat (2) cyc();
        check_eq("both_ready", {31'd0, ready}, 32'd1);
        check_eq("both_rdata", read_data, 32'h11112222);
        rd_en = 1'b0; wr_en = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
